ws2812_driver: RTL

WS2812_DRIVER -- requirements
Module: ws2812_driver

---
 rtl/ws2812_pkg.sv | 20 ++
 rtl/ws2812_bit_tx.sv | 50 +++++
 rtl/ws2812_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: frame controller states and default bit timing
// (12 MHz clock, 1.25 us per bit, 300 us latch gap).
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4
    } state_t;

    localparam int DEF_NUM_LEDS  = 20;
    localparam int DEF_T_BIT     = 15;
    localparam int DEF_T0H       = 5;
    localparam int DEF_T1H       = 10;
    localparam int DEF_T_RESET   = 3600;
    localparam int BITS_PER_LED  = 24;

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit waveform generator: a start pulse begins a T_BIT-cycle bit whose
// high time depends on bit_val; bit_end flags the last cycle of the bit.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T_BIT = DEF_T_BIT,
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic bit_end
);
    localparam int CW = $clog2(T_BIT + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] high_reg;
    logic          active_reg;
    logic          dout_reg;

    assign bit_end = active_reg && (cnt_reg == CW'(T_BIT - 1));
    assign dout    = dout_reg;

    // dout is registered so the line never glitches; it shows cnt < high_time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg    <= '0;
            high_reg   <= '0;
            active_reg <= 1'b0;
            dout_reg   <= 1'b0;
        end else if (start) begin
            cnt_reg    <= '0;
            high_reg   <= bit_val ? CW'(T1H) : CW'(T0H);
            active_reg <= 1'b1;
            dout_reg   <= 1'b1;
        end else if (active_reg) begin
            if (bit_end) begin
                active_reg <= 1'b0;
                dout_reg   <= 1'b0;
            end else begin
                cnt_reg  <= cnt_reg + CW'(1);
                dout_reg <= (cnt_reg + CW'(1)) < high_reg;
            end
        end
    end

endmodule

// File: rtl/ws2812_driver.sv
// WS2812 frame driver: reads NUM_LEDS GRB words from a colour ROM and streams
// them back-to-back, prefetching the next word, then holds the latch gap.
module ws2812_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_base_addr,
    output logic [7:0]  o_rom_addr,
    output logic        o_rom_ren,
    input  logic [23:0] i_rom_data,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_done
);
    localparam int         LW       = $clog2(T_RESET + 1);
    localparam logic [8:0] LAST_IDX = 9'(NUM_LEDS - 1);

    state_t        state_reg, state_next;
    logic [7:0]    base_reg, base_next;
    logic [7:0]    index_reg, index_next;
    logic [7:0]    addr_reg;
    logic [23:0]   shift_reg, shift_next;
    logic [23:0]   pf_reg, pf_next;
    logic          pf_pending_reg, pf_pending_next;
    logic          first_reg, first_next;
    logic          done_reg, done_next;
    logic [4:0]    bit_cnt_reg, bit_cnt_next;
    logic [LW-1:0] lat_cnt_reg, lat_cnt_next;

    logic          tx_start, tx_bit, tx_bit_end;
    logic          rom_ren, more_leds;
    logic [7:0]    rom_addr;

    ws2812_bit_tx #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_tx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (tx_start),
        .bit_val (tx_bit),
        .dout    (o_dout),
        .bit_end (tx_bit_end)
    );

    assign more_leds  = {1'b0, index_reg} < LAST_IDX;
    assign o_rom_ren  = rom_ren;
    assign o_rom_addr = rom_addr;
    assign o_busy     = (state_reg != IDLE);
    assign o_done     = done_reg;

    always_comb begin
        state_next   = state_reg;
        base_next    = base_reg;
        index_next   = index_reg;
        shift_next   = shift_reg;
        pf_next      = pf_reg;
        first_next   = 1'b0;
        done_next    = 1'b0;
        bit_cnt_next = bit_cnt_reg;
        lat_cnt_next = lat_cnt_reg;
        tx_start     = 1'b0;
        tx_bit       = 1'b0;
        rom_ren      = 1'b0;
        rom_addr     = addr_reg;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    base_next  = i_base_addr;
                    index_next = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rom_ren    = 1'b1;
                rom_addr   = base_reg + index_reg;
                state_next = LOAD;
            end
            LOAD: begin
                shift_next   = i_rom_data;
                tx_start     = 1'b1;
                tx_bit       = i_rom_data[23];
                bit_cnt_next = '0;
                first_next   = 1'b1;
                state_next   = SEND;
            end
            SEND: begin
                // Next LED's word is read while the current one is still shifting.
                if (first_reg && more_leds) begin
                    rom_ren  = 1'b1;
                    rom_addr = base_reg + index_reg + 8'd1;
                end
                if (pf_pending_reg) begin
                    pf_next = i_rom_data;
                end
                if (tx_bit_end) begin
                    if (bit_cnt_reg == 5'(BITS_PER_LED - 1)) begin
                        if (more_leds) begin
                            shift_next   = pf_reg;
                            tx_start     = 1'b1;
                            tx_bit       = pf_reg[23];
                            bit_cnt_next = '0;
                            index_next   = index_reg + 8'd1;
                            first_next   = 1'b1;
                        end else begin
                            lat_cnt_next = '0;
                            state_next   = LATCH;
                        end
                    end else begin
                        shift_next   = {shift_reg[22:0], 1'b0};
                        tx_start     = 1'b1;
                        tx_bit       = shift_reg[22];
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            LATCH: begin
                if (lat_cnt_reg == LW'(T_RESET - 1)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        pf_pending_next = rom_ren && (state_reg == SEND);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            index_reg      <= '0;
            addr_reg       <= '0;
            shift_reg      <= '0;
            pf_reg         <= '0;
            pf_pending_reg <= 1'b0;
            first_reg      <= 1'b0;
            done_reg       <= 1'b0;
            bit_cnt_reg    <= '0;
            lat_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            index_reg      <= index_next;
            addr_reg       <= rom_addr;
            shift_reg      <= shift_next;
            pf_reg         <= pf_next;
            pf_pending_reg <= pf_pending_next;
            first_reg      <= first_next;
            done_reg       <= done_next;
            bit_cnt_reg    <= bit_cnt_next;
            lat_cnt_reg    <= lat_cnt_next;
        end
    end

endmodule
